// File: rtl/ext_line_memory.sv
// ext_line_memory: line-granular backing memory answering each cs/we request after a fixed LATENCY
module ext_line_memory #(
   parameter int LINE_BITS  = 256,
   parameter int DEPTH_LOG2 = 9,
   parameter int LATENCY    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          addr_i,
   input  logic [LINE_BITS-1:0] data_i,
   input  logic                 cs_i,
   input  logic                 we_i,
   output logic                 ack_o,
   output logic [LINE_BITS-1:0] data_o,
   output logic                 busy_o
);
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   state_t state, state_n;
   logic [7:0] cnt;
   logic [DEPTH_LOG2-1:0] idx;
   logic we_r;
   logic [LINE_BITS-1:0] data_r;
   logic [LINE_BITS-1:0] mem [2**DEPTH_LOG2];
   logic accept, fire;
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:5+DEPTH_LOG2], addr_i[4:0]};
   assign busy_o = state != IDLE;
   // counter starts at LATENCY-1 and completes when it reaches 0, so ack lands LATENCY edges after accept
   always_comb begin
      accept = state == IDLE && cs_i;
      fire = state == WAIT && cnt == 8'd0;
      state_n = state;
      case (state)
         IDLE: if (cs_i) state_n = WAIT;
         WAIT: if (fire) state_n = ACK;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 8'd0;
         ack_o <= 1'b0;
         data_o <= '0;
      end else begin
         state <= state_n;
         ack_o <= fire;
         if (accept) begin
            idx <= addr_i[5+DEPTH_LOG2-1:5];
            we_r <= we_i;
            data_r <= data_i;
            cnt <= 8'(LATENCY - 1);
         end else if (state == WAIT && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end
         if (fire && !we_r) data_o <= mem[idx];
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && fire && we_r) mem[idx] <= data_r;
   end
endmodule

// File: tb/tb_ext_line_memory.sv
// tb_ext_line_memory: directed checks of latency, handshake, aliasing and reset abort
module tb_ext_line_memory;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] addr = '0;
   logic [255:0] data = '0;
   logic cs_a = 1'b0, cs_b = 1'b0, we = 1'b0;
   logic ack_a, ack_b, busy_a, busy_b;
   logic [255:0] data_a, data_b;
   int errors = 0, checks = 0;
   localparam logic [255:0] A5 = {32{8'hA5}};
   localparam logic [255:0] P  = {4{64'h0123456789ABCDEF}};
   localparam logic [255:0] V  = {8{32'hDEADBEEF}};
   always #5 clk = ~clk;
   ext_line_memory #(.LATENCY(10)) dut_a (
      .clk(clk), .rst(rst), .addr_i(addr), .data_i(data), .cs_i(cs_a), .we_i(we),
      .ack_o(ack_a), .data_o(data_a), .busy_o(busy_a)
   );
   ext_line_memory #(.LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .addr_i(addr), .data_i(data), .cs_i(cs_b), .we_i(we),
      .ack_o(ack_b), .data_o(data_b), .busy_o(busy_b)
   );
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic req(input bit sel, input logic [31:0] a, input logic w, input logic [255:0] d,
                      input bit tog, input int exp_lat, input logic [255:0] exp_q, input string tag);
      int n, busy_n;
      addr = a;
      we = w;
      data = d;
      if (sel) cs_b = 1'b1; else cs_a = 1'b1;
      @(posedge clk);
      #1;
      cs_a = 1'b0;
      cs_b = 1'b0;
      n = 0;
      busy_n = 0;
      while (!(sel ? ack_b : ack_a) && n < 300) begin
         busy_n += int'(sel ? busy_b : busy_a);
         if (tog) begin
            addr = $urandom;
            we = n[0];
            data = {8{$urandom}};
            cs_a = n[0];
         end
         @(posedge clk);
         #1;
         n++;
      end
      cs_a = 1'b0;
      busy_n += int'(sel ? busy_b : busy_a);
      check({tag, "_lat"}, 256'(n), 256'(exp_lat));
      check({tag, "_busy"}, 256'(busy_n), 256'(exp_lat + 1));
      check({tag, "_data"}, sel ? data_b : data_a, exp_q);
      @(posedge clk);
      #1;
      check({tag, "_ackfall"}, 256'(sel ? ack_b : ack_a), 256'(0));
      check({tag, "_idle"}, 256'(sel ? busy_b : busy_a), 256'(0));
   endtask
   initial begin
      int t[3];
      int acks;
      cs_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 256'(ack_a), 256'(0));
      check("rst_data", data_a, 256'(0));
      check("rst_busy", 256'(busy_a), 256'(0));
      check("rst_busy_b", 256'(busy_b), 256'(0));
      rst = 1'b0;
      cs_a = 1'b0;
      @(posedge clk);
      #1;
      check("rst_cs_not_accepted", 256'(busy_a), 256'(0));
      req(0, 32'h0, 1'b1, A5, 0, 10, 256'(0), "wr0");
      req(0, 32'h0, 1'b0, '0, 0, 10, A5, "rd0");
      req(0, 32'h40, 1'b1, P, 0, 10, A5, "wr2");
      req(0, 32'h5C, 1'b0, '0, 0, 10, P, "rd2");
      req(0, 32'h40, 1'b0, '0, 1, 10, P, "tog");
      req(0, 32'h0, 1'b0, '0, 0, 10, A5, "rd0_after_tog");
      addr = 32'h0;
      we = 1'b0;
      cs_a = 1'b1;
      acks = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (ack_a) begin
            if (acks < 3) t[acks] = c;
            acks++;
            check("cont_data", data_a, A5);
         end
      end
      cs_a = 1'b0;
      check("cont_count", 256'(acks), 256'(3));
      check("cont_first", 256'(t[0]), 256'(11));
      check("cont_gap1", 256'(t[1] - t[0]), 256'(12));
      check("cont_gap2", 256'(t[2] - t[1]), 256'(12));
      repeat (20) @(posedge clk);
      #1;
      check("cont_drain", 256'(busy_a), 256'(0));
      req(0, 32'hE0, 1'b1, '0, 0, 10, A5, "wr7z");
      addr = 32'hE0;
      we = 1'b1;
      data = '1;
      cs_a = 1'b1;
      @(posedge clk);
      #1;
      cs_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ack", 256'(ack_a), 256'(0));
      check("abort_busy", 256'(busy_a), 256'(0));
      check("abort_data", data_a, 256'(0));
      rst = 1'b0;
      acks = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         acks += int'(ack_a);
      end
      check("abort_noack", 256'(acks), 256'(0));
      req(0, 32'hE0, 1'b0, '0, 0, 10, 256'(0), "rd7");
      req(1, 32'h4000, 1'b1, V, 0, 1, 256'(0), "b_wr");
      req(1, 32'h0, 1'b0, '0, 0, 1, V, "b_rd");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
